// File: rtl/memory_access.sv
// MEM stage of the RV32I pipeline: one req/ack data-memory transaction per load/store,
// byte-lane alignment, branch resolution and the MEM/WB register.
module memory_access #(
    parameter int ACK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic [31:0] ALU_co_pype,
    input  logic [31:0] read_data2_pype2,
    input  logic [31:0] PCBranch_pype,
    input  logic [31:0] PCp4_pype2,
    input  logic [4:0]  WReg_pype2,
    input  logic        RegWrite_pype2,
    input  logic [1:0]  MemtoReg_pype2,
    input  logic [1:0]  MemRW_pype2,
    input  logic [2:0]  MemBranch_pype2,
    input  logic [31:0] Instraction_pype2,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall_mem,
    output logic        branch_taken,
    output logic [31:0] branch_PC,
    output logic        mem_err,
    output logic [31:0] ALU_co_pype3,
    output logic [31:0] load_data_pype3,
    output logic [31:0] PCp4_pype3,
    output logic [4:0]  WReg_pype3,
    output logic        RegWrite_pype3,
    output logic [1:0]  MemtoReg_pype3,
    output logic [31:0] Instraction_pype3
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_t        r_state;
    logic [CW-1:0] r_waitCnt;
    logic [31:0]   r_aluHold, r_pcp4Hold, r_instrHold, r_loadData;
    logic [4:0]    r_wregHold;
    logic          r_regWriteHold, r_isLoad;
    logic [1:0]    r_memtoRegHold, r_offset;
    logic [2:0]    r_funct3;

    logic [2:0]  w_funct3;
    logic        w_isLoad, w_isStore, w_memOp, w_isByte, w_isHalf, w_aligned;
    logic        w_start, w_misaligned, w_timeout, w_taken;
    logic [31:0] w_storeData, w_loadExt;
    logic [3:0]  w_storeBe;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_wrPype3, w_nRegWrite;
    logic [31:0] w_nAlu, w_nLoad, w_nPcp4, w_nInstr;
    logic [4:0]  w_nWReg;
    logic [1:0]  w_nMemtoReg;

    assign w_funct3     = Instraction_pype2[14:12];
    assign w_isLoad     = (MemRW_pype2 == 2'b01);
    assign w_isStore    = (MemRW_pype2 == 2'b10);
    assign w_memOp      = w_isLoad | w_isStore;
    assign w_isByte     = (w_funct3[1:0] == 2'b00);
    assign w_isHalf     = (w_funct3[1:0] == 2'b01);
    assign w_aligned    = w_isByte | (w_isHalf & ~ALU_co_pype[0])
                        | (~w_isByte & ~w_isHalf & (ALU_co_pype[1:0] == 2'b00));
    assign w_start      = (r_state == IDLE) && w_memOp && !nop && w_aligned;
    assign w_misaligned = (r_state == IDLE) && w_memOp && !nop && !w_aligned;
    assign w_timeout    = (r_state == ACCESS) && !dmem_ack && (r_waitCnt == CW'(ACK_TIMEOUT - 1));

    // DONE also stalls: upstream advanced at the ack edge and that instruction must wait a cycle.
    assign stall_mem = !rst && (w_start || ((r_state == ACCESS) && !dmem_ack && !w_timeout)
                                || (r_state == DONE));

    always_comb begin
        w_taken = 1'b0;
        case (MemBranch_pype2)
            3'b001:         w_taken = (ALU_co_pype == 32'd0);
            3'b010:         w_taken = (ALU_co_pype != 32'd0);
            3'b011, 3'b110: w_taken = ALU_co_pype[0];
            3'b101, 3'b111: w_taken = !ALU_co_pype[0];
            3'b100:         w_taken = 1'b1;
            default:        w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_storeData = read_data2_pype2;
        w_storeBe   = 4'b1111;
        if (w_isByte) begin
            w_storeData = {4{read_data2_pype2[7:0]}};
            w_storeBe   = 4'b0001 << ALU_co_pype[1:0];
        end else if (w_isHalf) begin
            w_storeData = {2{read_data2_pype2[15:0]}};
            w_storeBe   = ALU_co_pype[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (r_offset)
            2'b01:   w_byte = dmem_rdata[15:8];
            2'b10:   w_byte = dmem_rdata[23:16];
            2'b11:   w_byte = dmem_rdata[31:24];
            default: w_byte = dmem_rdata[7:0];
        endcase
        w_half    = r_offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_loadExt = dmem_rdata;
        case (r_funct3)
            3'b000:  w_loadExt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_loadExt = {{16{w_half[15]}}, w_half};
            3'b100:  w_loadExt = {24'd0, w_byte};
            3'b101:  w_loadExt = {16'd0, w_half};
            default: w_loadExt = dmem_rdata;
        endcase
    end

    // Next MEM/WB contents; anything not explicitly passed through is a bubble.
    always_comb begin
        w_wrPype3   = 1'b0;
        w_nAlu      = '0;
        w_nLoad     = '0;
        w_nPcp4     = '0;
        w_nWReg     = '0;
        w_nRegWrite = 1'b0;
        w_nMemtoReg = '0;
        w_nInstr    = '0;
        if (!keep) begin
            case (r_state)
                IDLE: begin
                    w_wrPype3 = 1'b1;
                    if (!nop && !w_memOp) begin
                        w_nAlu      = ALU_co_pype;
                        w_nPcp4     = PCp4_pype2;
                        w_nWReg     = WReg_pype2;
                        w_nRegWrite = RegWrite_pype2;
                        w_nMemtoReg = MemtoReg_pype2;
                        w_nInstr    = Instraction_pype2;
                    end
                end
                ACCESS: w_wrPype3 = w_timeout;
                DONE: begin
                    w_wrPype3   = 1'b1;
                    w_nAlu      = r_aluHold;
                    w_nLoad     = r_loadData;
                    w_nPcp4     = r_pcp4Hold;
                    w_nWReg     = r_wregHold;
                    w_nRegWrite = r_regWriteHold;
                    w_nMemtoReg = r_memtoRegHold;
                    w_nInstr    = r_instrHold;
                end
                default: w_wrPype3 = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= IDLE;
            r_waitCnt         <= '0;
            dmem_req          <= 1'b0;
            dmem_we           <= 1'b0;
            dmem_addr         <= '0;
            dmem_wdata        <= '0;
            dmem_be           <= '0;
            branch_taken      <= 1'b0;
            branch_PC         <= '0;
            mem_err           <= 1'b0;
            ALU_co_pype3      <= '0;
            load_data_pype3   <= '0;
            PCp4_pype3        <= '0;
            WReg_pype3        <= '0;
            RegWrite_pype3    <= 1'b0;
            MemtoReg_pype3    <= '0;
            Instraction_pype3 <= '0;
            r_aluHold         <= '0;
            r_pcp4Hold        <= '0;
            r_instrHold       <= '0;
            r_loadData        <= '0;
            r_wregHold        <= '0;
            r_regWriteHold    <= 1'b0;
            r_isLoad          <= 1'b0;
            r_memtoRegHold    <= '0;
            r_offset          <= '0;
            r_funct3          <= '0;
        end else begin
            branch_taken <= 1'b0;
            mem_err      <= 1'b0;
            if (w_wrPype3) begin
                ALU_co_pype3      <= w_nAlu;
                load_data_pype3   <= w_nLoad;
                PCp4_pype3        <= w_nPcp4;
                WReg_pype3        <= w_nWReg;
                RegWrite_pype3    <= w_nRegWrite;
                MemtoReg_pype3    <= w_nMemtoReg;
                Instraction_pype3 <= w_nInstr;
            end
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state        <= ACCESS;
                        r_waitCnt      <= '0;
                        dmem_req       <= 1'b1;
                        dmem_we        <= w_isStore;
                        dmem_addr      <= {ALU_co_pype[31:2], 2'b00};
                        dmem_wdata     <= w_storeData;
                        dmem_be        <= w_storeBe;
                        r_aluHold      <= ALU_co_pype;
                        r_pcp4Hold     <= PCp4_pype2;
                        r_instrHold    <= Instraction_pype2;
                        r_wregHold     <= WReg_pype2;
                        r_regWriteHold <= RegWrite_pype2 && w_isLoad;
                        r_memtoRegHold <= MemtoReg_pype2;
                        r_isLoad       <= w_isLoad;
                        r_offset       <= ALU_co_pype[1:0];
                        r_funct3       <= w_funct3;
                    end else if (w_misaligned) begin
                        mem_err <= 1'b1;
                    end else if (w_taken && !keep && !nop && !w_memOp) begin
                        branch_taken <= 1'b1;
                        branch_PC    <= PCBranch_pype;
                    end
                end
                ACCESS: begin
                    if (dmem_ack) begin
                        dmem_req   <= 1'b0;
                        dmem_we    <= 1'b0;
                        r_loadData <= r_isLoad ? w_loadExt : '0;
                        r_state    <= DONE;
                    end else if (w_timeout) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        mem_err  <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!keep) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: one task per feature, hand-computed expectations.
module tb_memory_access;
    logic        clk = 1'b0;
    logic        rst, keep, nop;
    logic [31:0] ALU_co_pype, read_data2_pype2, PCBranch_pype, PCp4_pype2, Instraction_pype2, dmem_rdata;
    logic [4:0]  WReg_pype2;
    logic        RegWrite_pype2, dmem_ack;
    logic [1:0]  MemtoReg_pype2, MemRW_pype2;
    logic [2:0]  MemBranch_pype2;
    logic        dmem_req, dmem_we, stall_mem, branch_taken, mem_err, RegWrite_pype3;
    logic [31:0] dmem_addr, dmem_wdata, branch_PC, ALU_co_pype3, load_data_pype3, PCp4_pype3, Instraction_pype3;
    logic [3:0]  dmem_be;
    logic [4:0]  WReg_pype3;
    logic [1:0]  MemtoReg_pype3;

    int checks = 0;
    int errors = 0;

    memory_access #(.ACK_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .keep(keep), .nop(nop),
        .ALU_co_pype(ALU_co_pype), .read_data2_pype2(read_data2_pype2),
        .PCBranch_pype(PCBranch_pype), .PCp4_pype2(PCp4_pype2),
        .WReg_pype2(WReg_pype2), .RegWrite_pype2(RegWrite_pype2),
        .MemtoReg_pype2(MemtoReg_pype2), .MemRW_pype2(MemRW_pype2),
        .MemBranch_pype2(MemBranch_pype2), .Instraction_pype2(Instraction_pype2),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .stall_mem(stall_mem),
        .branch_taken(branch_taken), .branch_PC(branch_PC), .mem_err(mem_err),
        .ALU_co_pype3(ALU_co_pype3), .load_data_pype3(load_data_pype3),
        .PCp4_pype3(PCp4_pype3), .WReg_pype3(WReg_pype3),
        .RegWrite_pype3(RegWrite_pype3), .MemtoReg_pype3(MemtoReg_pype3),
        .Instraction_pype3(Instraction_pype3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        ALU_co_pype = 0; read_data2_pype2 = 0; PCBranch_pype = 0; PCp4_pype2 = 0;
        WReg_pype2 = 0; RegWrite_pype2 = 0; MemtoReg_pype2 = 0; MemRW_pype2 = 0;
        MemBranch_pype2 = 0; Instraction_pype2 = 0;
    endtask

    task automatic driveOp(input logic [1:0] rw, input logic [2:0] f3, input logic [31:0] alu,
                           input logic [31:0] rs2, input logic [4:0] wreg, input logic regWrite);
        MemRW_pype2 = rw;
        Instraction_pype2 = {17'd0, f3, 12'h003};
        ALU_co_pype = alu;
        read_data2_pype2 = rs2;
        WReg_pype2 = wreg;
        RegWrite_pype2 = regWrite;
        MemtoReg_pype2 = (rw == 2'b01) ? 2'b01 : 2'b00;
        PCp4_pype2 = 32'h1000 + alu;
        MemBranch_pype2 = 3'b000;
        #1;
    endtask

    // Op already driven in cycle 0; ack arrives after waitCycles ACCESS cycles; ends after the DONE edge.
    task automatic memTxn(input int waitCycles, input logic [31:0] rdata);
        tick();
        repeat (waitCycles) tick();
        dmem_ack = 1'b1; dmem_rdata = rdata;
        tick();
        dmem_ack = 1'b0; dmem_rdata = 0;
        clearInputs();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; keep = 0; nop = 0; dmem_ack = 0; dmem_rdata = 0;
        clearInputs();
        tick(); tick();
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req got %b want 0", dmem_req); end
        checks++; if (stall_mem !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b want 0", stall_mem); end
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_branch got %b want 0", branch_taken); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", mem_err); end
        checks++; if (RegWrite_pype3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwrite got %b want 0", RegWrite_pype3); end
        checks++; if (ALU_co_pype3 !== 32'd0) begin errors++; $display("[TB] FAIL reset_alu got %h want 0", ALU_co_pype3); end
        checks++; if (dmem_be !== 4'd0) begin errors++; $display("[TB] FAIL reset_be got %b want 0", dmem_be); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        logic [31:0] alus [2] = '{32'h12345678, 32'hCAFEBABE};
        logic [4:0]  wregs [2] = '{5'd7, 5'd31};
        logic [1:0]  rws [2] = '{2'b00, 2'b11};
        for (int i = 0; i < 2; i++) begin
            clearInputs();
            ALU_co_pype = alus[i]; WReg_pype2 = wregs[i]; RegWrite_pype2 = 1'b1;
            MemtoReg_pype2 = 2'b10; PCp4_pype2 = 32'h104 + i; Instraction_pype2 = 32'h00A00333 + i;
            MemRW_pype2 = rws[i];
            #1;
            checks++; if (stall_mem !== 1'b0) begin errors++; $display("[TB] FAIL pass_stall[%0d] got %b want 0", i, stall_mem); end
            tick();
            checks++; if (ALU_co_pype3 !== alus[i]) begin errors++; $display("[TB] FAIL pass_alu[%0d] got %h want %h", i, ALU_co_pype3, alus[i]); end
            checks++; if (WReg_pype3 !== wregs[i]) begin errors++; $display("[TB] FAIL pass_wreg[%0d] got %0d want %0d", i, WReg_pype3, wregs[i]); end
            checks++; if (RegWrite_pype3 !== 1'b1) begin errors++; $display("[TB] FAIL pass_regwrite[%0d] got %b want 1", i, RegWrite_pype3); end
            checks++; if (MemtoReg_pype3 !== 2'b10) begin errors++; $display("[TB] FAIL pass_memtoreg[%0d] got %b want 10", i, MemtoReg_pype3); end
            checks++; if (PCp4_pype3 !== 32'h104 + i) begin errors++; $display("[TB] FAIL pass_pcp4[%0d] got %h", i, PCp4_pype3); end
            checks++; if (Instraction_pype3 !== 32'h00A00333 + i) begin errors++; $display("[TB] FAIL pass_instr[%0d] got %h", i, Instraction_pype3); end
            checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL pass_req[%0d] got %b want 0", i, dmem_req); end
        end
        clearInputs();
    endtask

    task automatic test_nop();
        clearInputs();
        ALU_co_pype = 32'h99; WReg_pype2 = 5'd6; RegWrite_pype2 = 1'b1; MemtoReg_pype2 = 2'b01;
        nop = 1'b1;
        tick();
        checks++; if (RegWrite_pype3 !== 1'b0) begin errors++; $display("[TB] FAIL nop_regwrite got %b want 0", RegWrite_pype3); end
        checks++; if (ALU_co_pype3 !== 32'd0) begin errors++; $display("[TB] FAIL nop_alu got %h want 0", ALU_co_pype3); end
        checks++; if (MemtoReg_pype3 !== 2'b00) begin errors++; $display("[TB] FAIL nop_memtoreg got %b want 00", MemtoReg_pype3); end
        driveOp(2'b01, 3'b010, 32'h100, 0, 5'd2, 1'b1);
        checks++; if (stall_mem !== 1'b0) begin errors++; $display("[TB] FAIL nop_lw_stall got %b want 0", stall_mem); end
        tick();
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL nop_lw_req got %b want 0", dmem_req); end
        nop = 1'b0;
        clearInputs();
        tick();
    endtask

    task automatic test_lw();
        int cnt;
        driveOp(2'b01, 3'b010, 32'h100, 0, 5'd5, 1'b1);
        cnt = stall_mem ? 1 : 0;
        tick();
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL lw_req got %b want 1", dmem_req); end
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("[TB] FAIL lw_we got %b want 0", dmem_we); end
        checks++; if (dmem_be !== 4'b1111) begin errors++; $display("[TB] FAIL lw_be got %b want 1111", dmem_be); end
        checks++; if (dmem_addr !== 32'h100) begin errors++; $display("[TB] FAIL lw_addr got %h want 100", dmem_addr); end
        for (int c = 1; c < 4; c++) begin
            if (stall_mem) cnt++;
            tick();
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (stall_mem !== 1'b0) begin errors++; $display("[TB] FAIL lw_ack_stall got %b want 0", stall_mem); end
        checks++; if (cnt !== 4) begin errors++; $display("[TB] FAIL lw_stall_cycles got %0d want 4", cnt); end
        tick();
        dmem_ack = 1'b0; dmem_rdata = 0;
        clearInputs();
        tick();
        checks++; if (load_data_pype3 !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lw_data got %h want deadbeef", load_data_pype3); end
        checks++; if (WReg_pype3 !== 5'd5) begin errors++; $display("[TB] FAIL lw_wreg got %0d want 5", WReg_pype3); end
        checks++; if (RegWrite_pype3 !== 1'b1) begin errors++; $display("[TB] FAIL lw_regwrite got %b want 1", RegWrite_pype3); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL lw_req_done got %b want 0", dmem_req); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
        logic [31:0] addrs [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
        logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF, 32'hFFFFFFFF};
        for (int i = 0; i < 5; i++) begin
            driveOp(2'b01, f3s[i], addrs[i], 0, 5'd8, 1'b1);
            memTxn(1, 32'h80FFFFFF);
            checks++; if (load_data_pype3 !== exps[i]) begin errors++; $display("[TB] FAIL load_ext[%0d] got %h want %h", i, load_data_pype3, exps[i]); end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3s [3] = '{3'b001, 3'b000, 3'b010};
        logic [31:0] addrs [3] = '{32'h0A, 32'h0B, 32'h10};
        logic [31:0] wdat [3] = '{32'hABCDABCD, 32'hCDCDCDCD, 32'h1234ABCD};
        logic [3:0]  bes [3] = '{4'b1100, 4'b1000, 4'b1111};
        logic [31:0] wadr [3] = '{32'h08, 32'h08, 32'h10};
        for (int i = 0; i < 3; i++) begin
            driveOp(2'b10, f3s[i], addrs[i], 32'h1234ABCD, 5'd0, 1'b0);
            tick();
            checks++; if (dmem_we !== 1'b1) begin errors++; $display("[TB] FAIL st_we[%0d] got %b want 1", i, dmem_we); end
            checks++; if (dmem_be !== bes[i]) begin errors++; $display("[TB] FAIL st_be[%0d] got %b want %b", i, dmem_be, bes[i]); end
            checks++; if (dmem_wdata !== wdat[i]) begin errors++; $display("[TB] FAIL st_wdata[%0d] got %h want %h", i, dmem_wdata, wdat[i]); end
            checks++; if (dmem_addr !== wadr[i]) begin errors++; $display("[TB] FAIL st_addr[%0d] got %h want %h", i, dmem_addr, wadr[i]); end
            dmem_ack = 1'b1;
            tick();
            dmem_ack = 1'b0;
            clearInputs();
            tick();
            checks++; if (RegWrite_pype3 !== 1'b0) begin errors++; $display("[TB] FAIL st_regwrite[%0d] got %b want 0", i, RegWrite_pype3); end
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  rws [3] = '{2'b10, 2'b01, 2'b01};
        logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b010};
        logic [31:0] addrs [3] = '{32'h102, 32'h101, 32'h102};
        for (int i = 0; i < 3; i++) begin
            driveOp(rws[i], f3s[i], addrs[i], 32'h55, 5'd9, 1'b1);
            checks++; if (stall_mem !== 1'b0) begin errors++; $display("[TB] FAIL mis_stall[%0d] got %b want 0", i, stall_mem); end
            tick();
            checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_req[%0d] got %b want 0", i, dmem_req); end
            checks++; if (mem_err !== 1'b1) begin errors++; $display("[TB] FAIL mis_err[%0d] got %b want 1", i, mem_err); end
            checks++; if (RegWrite_pype3 !== 1'b0) begin errors++; $display("[TB] FAIL mis_regwrite[%0d] got %b want 0", i, RegWrite_pype3); end
            clearInputs();
            tick();
            checks++; if (mem_err !== 1'b0) begin errors++; $display("[TB] FAIL mis_err_pulse[%0d] got %b want 0", i, mem_err); end
        end
    endtask

    task automatic test_timeout();
        driveOp(2'b01, 3'b010, 32'h200, 0, 5'd11, 1'b1);
        tick();
        for (int c = 1; c < 64; c++) tick();
        checks++; if (mem_err !== 1'b0) begin errors++; $display("[TB] FAIL to_early_err got %b want 0", mem_err); end
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL to_req_held got %b want 1", dmem_req); end
        clearInputs();
        tick();
        checks++; if (mem_err !== 1'b1) begin errors++; $display("[TB] FAIL to_err got %b want 1", mem_err); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL to_req got %b want 0", dmem_req); end
        checks++; if (RegWrite_pype3 !== 1'b0) begin errors++; $display("[TB] FAIL to_regwrite got %b want 0", RegWrite_pype3); end
        ALU_co_pype = 32'h3C; RegWrite_pype2 = 1'b1; WReg_pype2 = 5'd12;
        tick();
        checks++; if (ALU_co_pype3 !== 32'h3C) begin errors++; $display("[TB] FAIL to_idle got %h want 3c", ALU_co_pype3); end
        clearInputs();
    endtask

    task automatic test_branch();
        logic [2:0]  brs [8] = '{3'b010, 3'b111, 3'b001, 3'b001, 3'b011, 3'b101, 3'b110, 3'b100};
        logic [31:0] alus [8] = '{32'd5, 32'd1, 32'd0, 32'd3, 32'd1, 32'd0, 32'd0, 32'h99};
        logic        exps [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            clearInputs();
            MemBranch_pype2 = brs[i]; ALU_co_pype = alus[i]; PCBranch_pype = 32'h40 + 4 * i;
            #1;
            tick();
            checks++; if (branch_taken !== exps[i]) begin errors++; $display("[TB] FAIL br_taken[%0d] got %b want %b", i, branch_taken, exps[i]); end
            if (exps[i]) begin
                checks++; if (branch_PC !== 32'h40 + 4 * i) begin errors++; $display("[TB] FAIL br_pc[%0d] got %h want %h", i, branch_PC, 32'h40 + 4 * i); end
            end
            clearInputs();
            tick();
            checks++; if (branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL br_pulse[%0d] got %b want 0", i, branch_taken); end
        end
        driveOp(2'b01, 3'b010, 32'h100, 0, 5'd1, 1'b1);
        MemBranch_pype2 = 3'b100; PCBranch_pype = 32'h80;
        tick();
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL br_memop got %b want 0", branch_taken); end
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL br_memop_req got %b want 1", dmem_req); end
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        clearInputs();
        tick();
        checks++; if (branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL br_memop_done got %b want 0", branch_taken); end
    endtask

    task automatic test_reset_mid();
        driveOp(2'b01, 3'b010, 32'h400, 0, 5'd3, 1'b1);
        tick();
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_req_before got %b want 1", dmem_req); end
        rst = 1'b1;
        tick();
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_req got %b want 0", dmem_req); end
        checks++; if (stall_mem !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stall got %b want 0", stall_mem); end
        checks++; if (dmem_addr !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_addr got %h want 0", dmem_addr); end
        checks++; if (dmem_be !== 4'd0) begin errors++; $display("[TB] FAIL rstmid_be got %b want 0", dmem_be); end
        clearInputs();
        rst = 1'b0;
        ALU_co_pype = 32'h5A; RegWrite_pype2 = 1'b1; WReg_pype2 = 5'd4;
        tick();
        checks++; if (ALU_co_pype3 !== 32'h5A) begin errors++; $display("[TB] FAIL rstmid_idle got %h want 5a", ALU_co_pype3); end
        clearInputs();
    endtask

    task automatic test_keep();
        clearInputs();
        ALU_co_pype = 32'h77; RegWrite_pype2 = 1'b1; WReg_pype2 = 5'd3;
        tick();
        driveOp(2'b01, 3'b010, 32'h300, 0, 5'd9, 1'b1);
        keep = 1'b1;
        tick();
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("[TB] FAIL keep_req got %b want 1", dmem_req); end
        dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
        tick();
        dmem_ack = 1'b0; dmem_rdata = 0;
        clearInputs();
        tick();
        checks++; if (ALU_co_pype3 !== 32'h77) begin errors++; $display("[TB] FAIL keep_alu_hold got %h want 77", ALU_co_pype3); end
        checks++; if (WReg_pype3 !== 5'd3) begin errors++; $display("[TB] FAIL keep_wreg_hold got %0d want 3", WReg_pype3); end
        checks++; if (load_data_pype3 !== 32'd0) begin errors++; $display("[TB] FAIL keep_data_hold got %h want 0", load_data_pype3); end
        keep = 1'b0;
        tick();
        checks++; if (load_data_pype3 !== 32'h11223344) begin errors++; $display("[TB] FAIL keep_data got %h want 11223344", load_data_pype3); end
        checks++; if (ALU_co_pype3 !== 32'h300) begin errors++; $display("[TB] FAIL keep_alu got %h want 300", ALU_co_pype3); end
        checks++; if (WReg_pype3 !== 5'd9) begin errors++; $display("[TB] FAIL keep_wreg got %0d want 9", WReg_pype3); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_nop();
        test_lw();
        test_load_ext();
        test_store();
        test_misaligned();
        test_timeout();
        test_branch();
        test_reset_mid();
        test_keep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
